bus_split_arbiter: RTL
======================

BUS_SPLIT_ARBITER -- requirements
Module: bus_split_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64, maximum cycles a single grant is held before forced revoke (used only with ARB_TIMEOUT_EN).
REQ-002 Parameter CNT_W, 8, width of the grant-hold counter; TIMEOUT_CYCLES SHALL be at most 2^CNT_W-1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_m_1  input  1  bus request from master port 1; held high for the whole transaction.
REQ-006 req_m_2  input  1  bus request from master port 2; held high for the whole transaction.
REQ-007 req_split  input  1  split-slave port request to return split read data.
REQ-008 split_ack  input  1  one-cycle pulse from the slave side: current transaction has been split.
REQ-009 grant_m_1, grant_m_2, grant_split  output  1 each  registered one-hot grants.
REQ-010 sel  output  2  mux select: 00 M1, 01 M2, 10 split slave, 11 idle.
REQ-011 split_pending  output  1  a split transaction is outstanding.
REQ-012 split_owner  output  1  master owning the outstanding split (0 = M1, 1 = M2); valid only while split_pending.
REQ-013 split_err  output  1  one-cycle pulse when split_ack arrives while split_pending is already set.
REQ-014 timeout_err  output  1  one-cycle pulse on forced revoke (constant 0 without ARB_TIMEOUT_EN).

Function
REQ-015 FSM states SHALL be IDLE, GNT_M1, GNT_M2 and GNT_SPLIT; the grants and sel SHALL be registered decodes of the state.
REQ-016 In IDLE, winner priority SHALL be req_split first, then the masters by round-robin, with the master not granted last winning a tie; the grant SHALL assert on the cycle after the request is sampled.
REQ-017 A master with split_pending=1 and split_owner equal to itself SHALL be masked from arbitration.
REQ-018 GNT_Mx SHALL hold while req_m_x=1; on req_m_x=0 the FSM SHALL return to IDLE, deasserting the grant on the following edge; the last-granted pointer SHALL update to x.
REQ-019 split_ack in GNT_Mx with split_pending=0 SHALL set split_pending, set split_owner=x and return to IDLE on the next edge, even if req_m_x stays high.
REQ-020 GNT_SPLIT SHALL hold while req_split=1; on its fall, split_pending SHALL clear and the FSM SHALL go to IDLE.
REQ-021 There SHALL be exactly one IDLE cycle between any two grants (bus turnaround); back-to-back grants without IDLE are forbidden.
REQ-022 split_ack while split_pending=1 SHALL pulse split_err and leave split_owner unchanged; split_ack in IDLE or GNT_SPLIT SHALL be ignored.
REQ-023 split_ack coincident with req_m_x falling SHALL still record the split.
REQ-024 req_split with split_pending=0 SHALL still be granted; completion clears nothing.
REQ-025 At most one grant SHALL be high in any cycle.

Reset
REQ-026 While rst_n=0: state IDLE, all grants 0, sel=11, split_pending=0, split_owner=0, split_err=0, timeout_err=0, hold counter 0, and last-granted pointer = M2 so that M1 wins the first tie.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously) and discard any pending split.

Configuration
REQ-028 With macro BUS_SPLIT_ARBITER_TIMEOUT_EN defined, a hold counter SHALL count grant cycles; when it reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse timeout_err and, for a master grant, advance round-robin.
REQ-029 With the macro defined, a revoked GNT_SPLIT SHALL keep split_pending set.
REQ-030 Without the macro, no counter logic SHALL exist, grants SHALL be unbounded and timeout_err SHALL be tied to 0.

Verification
REQ-031 req_m_1 high for 5 cycles, then low -> grant_m_1 high cycles 2-6 after the request, sel=00 during the grant, then IDLE with sel=11.
REQ-032 req_m_1 and req_m_2 high together from reset, each dropping 3 cycles after its grant -> order M1, one IDLE cycle, M2; a repeated simultaneous request grants M1 again.
REQ-033 M1 granted, split_ack pulse, req_m_1 kept high -> grant drops, split_pending=1, split_owner=0, M1 not regranted; req_split high 4 cycles -> grant_split high, then split_pending=0.
REQ-034 Split pending for M1, then req_m_2 and req_split raised in the same cycle -> grant_split first, M2 after one IDLE cycle.
REQ-035 M2 granted while split_pending is already set, split_ack pulsed -> split_err pulses once and split_owner stays 0.
REQ-036 Macro defined, TIMEOUT_CYCLES=8, req_m_1 held high -> grant lasts 8 cycles, timeout_err pulses once, M1 is regranted after the IDLE cycle; rst_n pulsed low mid-grant -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/bus_split_arbiter.sv
// bus_split_arbiter: split-transaction bus arbiter for two masters and a split-slave return port.
// Define BUS_SPLIT_ARBITER_TIMEOUT_EN to add the grant-hold timeout.
module bus_split_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_m_1,
  input  logic       req_m_2,
  input  logic       req_split,
  input  logic       split_ack,
  output logic       grant_m_1,
  output logic       grant_m_2,
  output logic       grant_split,
  output logic [1:0] sel,
  output logic       split_pending,
  output logic       split_owner,
  output logic       split_err,
  output logic       timeout_err
);
  // State codes double as the sel encoding, so sel is the state register itself.
  localparam logic [1:0] GNT_M1 = 2'b00, GNT_M2 = 2'b01, GNT_SPLIT = 2'b10, IDLE = 2'b11;
  logic [1:0] state, state_nx, pick;
  logic last, last_nx, pend_nx, owner_nx;
  logic m1_ok, m2_ok, mst, cur_req, split_new, hold, revoke;
  always_comb begin
    m1_ok = req_m_1 & ~(split_pending & ~split_owner);
    m2_ok = req_m_2 & ~(split_pending & split_owner);
    pick = req_split ? GNT_SPLIT : (m1_ok & m2_ok) ? (last ? GNT_M1 : GNT_M2) :
           m1_ok ? GNT_M1 : m2_ok ? GNT_M2 : IDLE;
    mst = (state == GNT_M1) | (state == GNT_M2);
    cur_req = (state == GNT_M1) ? req_m_1 : (state == GNT_M2) ? req_m_2 : req_split;
    split_new = mst & split_ack & ~split_pending;
    hold = (state != IDLE) & cur_req & ~split_new;
    state_nx = (state == IDLE) ? pick : (hold & ~revoke) ? state : IDLE;
    last_nx = (state == IDLE && pick == GNT_M1) ? 1'b0 :
              (state == IDLE && pick == GNT_M2) ? 1'b1 : last;
    pend_nx = split_new ? 1'b1 : (state == GNT_SPLIT && !req_split) ? 1'b0 : split_pending;
    owner_nx = split_new ? state[0] : split_owner;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      grant_m_1 <= 1'b0;
      grant_m_2 <= 1'b0;
      grant_split <= 1'b0;
      split_pending <= 1'b0;
      split_owner <= 1'b0;
      split_err <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      grant_m_1 <= state_nx == GNT_M1;
      grant_m_2 <= state_nx == GNT_M2;
      grant_split <= state_nx == GNT_SPLIT;
      split_pending <= pend_nx;
      split_owner <= owner_nx;
      split_err <= mst & split_ack & split_pending;
    end
  assign sel = state;
`ifdef BUS_SPLIT_ARBITER_TIMEOUT_EN
  // Counter is zero on the first grant cycle, so a grant lasts exactly TIMEOUT_CYCLES.
  logic [CNT_W-1:0] cnt;
  assign revoke = hold & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
      timeout_err <= revoke;
    end
`else
  assign revoke = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
